imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Instruction-memory front end that sits directly upstream of the single-cycle MIPS core's fetch port.
- After reset it clears its instruction store to NOPs, then accepts a program as a valid/ready word stream.
- While loading, it holds the core in reset. Once the program is loaded, it releases the core and serves IR combinationally from IR_addr.

Parameters:
- ADDR_W, 7, word-address width; the store holds 2**ADDR_W 32-bit words (128 words = 512 B).
- NOP_WORD, 32'h0000_0000, fill and default instruction (sll $0,$0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ld_valid  in  1  a load word is present on ld_data.
- ld_data  in  32  instruction word to store.
- ld_last  in  1  qualifies ld_valid: this is the final program word.
- ld_ready  out  1  the loader accepts a word this cycle.
- IR_addr  in  32  byte fetch address from the core.
- IR  out  32  instruction to the core (combinational).
- core_rst_n  out  1  active-low reset to the core.
- load_done  out  1  program loaded; the core is running.
- load_err  out  1  sticky overflow error.
- word_cnt  out  ADDR_W+1  number of words accepted.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- States: CLEAR, LOAD, RUN, ERROR. A low rst_n at any edge forces CLEAR with clr_ptr=0, wr_ptr=0, word_cnt=0 and load_err=0. This applies from any state, including mid-load and RUN.
- CLEAR:
  - Writes NOP_WORD to mem[clr_ptr] each cycle and increments clr_ptr.
  - After writing word 2**ADDR_W-1, the next state is LOAD.
  - Lasts exactly 2**ADDR_W cycles.
  - ld_ready=0 throughout.
- LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready: mem[wr_ptr]<=ld_data, wr_ptr++, word_cnt++.
  - If ld_last is also set, the next state is RUN.
  - ld_valid=0 cycles are idle, with no state change.
- Overflow:
  - Trigger: a word is accepted at wr_ptr==2**ADDR_W-1 without ld_last.
  - That word is stored and word_cnt becomes 2**ADDR_W.
  - The next state is ERROR.
  - A word with ld_last at index 2**ADDR_W-1 is legal and goes to RUN.
- ERROR:
  - ld_ready=0, load_err=1 (sticky until reset).
  - The core stays in reset.
  - The store is not written.
- RUN:
  - ld_ready=0; ld_valid is ignored.
  - load_done=1.
  - word_cnt holds.
- core_rst_n = rst_n && (state==RUN), combinational from rst_n so the core resets on the same edge as the loader.
  - The core therefore sees its first non-reset edge one cycle after the edge that accepted the ld_last word.
  - Its first fetch is from IR_addr 0.
- IR (combinational):
  - In RUN: IR = mem[IR_addr[ADDR_W+1:2]] when IR_addr[31:ADDR_W+2]==0, else NOP_WORD.
  - IR_addr[1:0] is ignored.
  - In any other state: IR = NOP_WORD.
- Reset value of every output:
  - ld_ready=0, core_rst_n=0, load_done=0, load_err=0, word_cnt=0, IR=NOP_WORD.
- Simultaneous events:
  - rst_n low with ld_valid: the word is discarded and reset wins.
  - Reset during RUN: the store is wiped by CLEAR, so the program must be reloaded.
- The store has one write port (CLEAR or LOAD, never both) and one asynchronous read port. There is no reset on the array contents; CLEAR provides the defined contents.

Decomposition:
- Shared package (mips_pkg):
  - boot_state_t enum {CLEAR, LOAD, RUN, ERROR}.
  - NOP_WORD constant.
  - IMEM_ADDR_W default (7), which the core's address slicing also uses.
- Sub-module imem_array:
  - 2**ADDR_W x 32 storage.
  - Synchronous write port (we, waddr, wdata).
  - Combinational read port (raddr, rdata).
- imem_boot_loader contains the FSM, pointers, out-of-range and state muxing for IR, and core_rst_n.

Test Plan:
- Reset then idle: rst_n low 2 cycles, then high.
  - -> ld_ready=0 for exactly 128 cycles, then 1.
  - IR=0 and core_rst_n=0 throughout.
- Load with gaps: send 32'h2008_0005, 32'h2009_0003, then 32'h0109_5020 with ld_last, with ld_valid low 1 cycle between words.
  - -> word_cnt=3.
  - core_rst_n=1 and load_done=1 from the edge after word 3.
- Fetch in RUN (after the load above):
  - IR_addr=0x0 -> 32'h2008_0005.
  - IR_addr=0x6 -> 32'h2009_0003.
  - IR_addr=0xC -> 0.
  - IR_addr=0x200 -> 0 (out of range).
- Full load: 128 words, ld_last on word 127.
  - -> RUN, word_cnt=128, load_err=0.
  - IR_addr=0x1FC returns word 127.
- Overflow: 128 words with no ld_last.
  - -> load_err=1, ld_ready=0, core_rst_n=0.
  - A 129th ld_valid is not accepted.
  - Recovery: reset clears load_err and re-enters CLEAR.
- Reset mid-operation: assert rst_n low after 10 words, and again during RUN.
  - -> core_rst_n=0 on the same edge.
  - 128-cycle CLEAR follows.
  - After a subsequent 1-word load, IR_addr=0x4 returns 0; the old contents are wiped.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared boot-loader types and constants: FSM state encoding, fill word and the
// instruction-store address width.
package imem_boot_loader_pkg;

    localparam int unsigned IMEM_ADDR_W = 7;
    localparam int unsigned WORD_W      = 32;
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Program-load word stream: the source drives valid/data/last and the loader
// drives ready.
interface imem_boot_loader_if;
    import imem_boot_loader_pkg::*;

    logic              ld_valid;
    logic [WORD_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);

endinterface

// File: rtl/imem_boot_loader_array.sv
// Instruction store: one synchronous write port and one combinational read port.
// The contents have no reset; the loader's CLEAR pass defines them.
module imem_boot_loader_array
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory front end: wipes the store to NOPs, loads a program from a
// valid/ready stream while holding the core in reset, then serves IR.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_boot_loader_if.slave   ld,
    input  logic [WORD_W-1:0]   IR_addr,
    output logic [WORD_W-1:0]   IR,
    output logic                core_rst_n,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_W:0]     word_cnt
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WORD_W-1:0] mem_rdata;
    logic              ld_accept;
    logic              addr_in_range;
    logic              unused_addr_bits;

    // Gated by rst_n so a word offered during reset is never accepted.
    assign ld.ld_ready = rst_n && (state_q == LOAD);
    assign ld_accept   = ld.ld_valid && ld.ld_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        word_cnt_d = word_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr_q;
        mem_wdata  = NOP_WORD;

        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == PTR_LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ld_accept) begin
                    mem_we     = 1'b1;
                    mem_waddr  = wr_ptr_q;
                    mem_wdata  = ld.ld_data;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
                    // A last word in the final slot is legal; anything else there overflows.
                    if (ld.ld_last) begin
                        state_d = RUN;
                    end else if (wr_ptr_q == PTR_LAST) begin
                        state_d = ERROR;
                    end
                end
            end
            RUN:     ;
            ERROR:   ;
            default: ;
        endcase

        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    imem_boot_loader_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Byte address to word index; the core only issues word-aligned fetches.
    assign mem_raddr        = IR_addr[ADDR_W+1:2];
    assign addr_in_range    = (IR_addr[WORD_W-1:ADDR_W+2] == '0);
    assign unused_addr_bits = ^IR_addr[1:0];

    assign IR         = ((state_q == RUN) && addr_in_range) ? mem_rdata : NOP_WORD;
    assign core_rst_n = rst_n && (state_q == RUN);
    assign load_done  = (state_q == RUN);
    assign load_err   = (state_q == ERROR);
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table-driven load/fetch vectors plus
// hand-written reset, full-load and overflow sequences.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] IR_addr;
    logic [31:0] IR;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;
    logic [7:0]  word_cnt;

    int checks   = 0;
    int failures = 0;

    imem_boot_loader_if ld_if ();

    imem_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld_if.slave),
        .IR_addr    (IR_addr),
        .IR         (IR),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        exp_ready;
        logic [7:0]  exp_cnt;
        logic        exp_done;
    } ld_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_ir;
    } fetch_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with ld_ready low after reset release; bounded.
    task automatic wait_clear(output int n, output bit bad);
        n   = 0;
        bad = 1'b0;
        #1;
        while (!ld_if.ld_ready && n < 300) begin
            n++;
            if (core_rst_n !== 1'b0 || IR !== 32'h0) bad = 1'b1;
            step();
        end
    endtask

    task automatic do_reset();
        int  n;
        bit  bad;
        ld_if.ld_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_clear(n, bad);
        check("clear_len", 32'(n), 32'd128);
    endtask

    task automatic send_word(input logic [31:0] data, input logic last);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = data;
        ld_if.ld_last  = last;
        #1;
        if (ld_if.ld_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_ready: got %0b expected 1", ld_if.ld_ready);
        end
        step();
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
        IR_addr = addr;
        #1;
        check(name, IR, exp);
    endtask

    ld_vec_t    lv [6];
    fetch_vec_t fv [7];

    initial begin
        int n;
        bit bad;

        lv[0] = '{1'b1, 32'h2008_0005, 1'b0, 1'b1, 8'd1, 1'b0};
        lv[1] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd1, 1'b0};
        lv[2] = '{1'b1, 32'h2009_0003, 1'b0, 1'b1, 8'd2, 1'b0};
        lv[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd2, 1'b0};
        lv[4] = '{1'b1, 32'h0109_5020, 1'b1, 1'b1, 8'd3, 1'b1};
        lv[5] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'd3, 1'b1};

        fv[0] = '{32'h0000_0000, 32'h2008_0005};
        fv[1] = '{32'h0000_0006, 32'h2009_0003};
        fv[2] = '{32'h0000_000C, 32'h0000_0000};
        fv[3] = '{32'h0000_0008, 32'h0109_5020};
        fv[4] = '{32'h0000_0200, 32'h0000_0000};
        fv[5] = '{32'hFFFF_FFFC, 32'h0000_0000};
        fv[6] = '{32'h0000_01FC, 32'h0000_0000};

        rst_n          = 1'b0;
        IR_addr        = 32'h0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = 32'h0;
        ld_if.ld_last  = 1'b0;

        // Reset held two cycles, then the 128-cycle wipe.
        step();
        step();
        check("rst_ld_ready",   32'(ld_if.ld_ready), 32'd0);
        check("rst_core_rst_n", 32'(core_rst_n),     32'd0);
        check("rst_load_done",  32'(load_done),      32'd0);
        check("rst_load_err",   32'(load_err),       32'd0);
        check("rst_word_cnt",   32'(word_cnt),       32'd0);
        check("rst_ir",         IR,                  32'h0);
        rst_n = 1'b1;
        wait_clear(n, bad);
        check("clear_len_first", 32'(n), 32'd128);
        check("clear_quiet", 32'(bad), 32'd0);

        // Load with idle gaps; RUN ignores the trailing valid.
        for (int i = 0; i < 6; i++) begin
            ld_if.ld_valid = lv[i].valid;
            ld_if.ld_data  = lv[i].data;
            ld_if.ld_last  = lv[i].last;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(ld_if.ld_ready), 32'(lv[i].exp_ready));
            step();
            check($sformatf("vec%0d_cnt", i),   32'(word_cnt),   32'(lv[i].exp_cnt));
            check($sformatf("vec%0d_done", i),  32'(load_done),  32'(lv[i].exp_done));
            check($sformatf("vec%0d_crst", i),  32'(core_rst_n), 32'(lv[i].exp_done));
        end
        ld_if.ld_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fetch($sformatf("fetch%0d", i), fv[i].addr, fv[i].exp_ir);
        end

        // Reset during RUN: core reset follows rst_n immediately, store is wiped.
        rst_n = 1'b0;
        #1;
        check("run_rst_crst_comb", 32'(core_rst_n), 32'd0);
        step();
        check("run_rst_done", 32'(load_done), 32'd0);
        check("run_rst_cnt",  32'(word_cnt),  32'd0);
        rst_n = 1'b1;
        wait_clear(n, bad);
        check("run_rst_clear_len", 32'(n), 32'd128);
        send_word(32'h1111_1111, 1'b1);
        fetch("reload_w0", 32'h0, 32'h1111_1111);
        fetch("reload_w1_wiped", 32'h4, 32'h0);

        // Full 128-word load with last on the final slot.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            send_word(32'hA500_0000 | 32'(i), (i == 127));
        end
        check("full_done", 32'(load_done), 32'd1);
        check("full_cnt",  32'(word_cnt),  32'd128);
        check("full_err",  32'(load_err),  32'd0);
        fetch("full_w127", 32'h1FC, 32'hA500_007F);
        fetch("full_w64",  32'h100, 32'hA500_0040);

        // Overflow: 128 words without last.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            send_word(32'h5A00_0000 | 32'(i), 1'b0);
        end
        check("ovf_err",   32'(load_err),       32'd1);
        check("ovf_ready", 32'(ld_if.ld_ready), 32'd0);
        check("ovf_crst",  32'(core_rst_n),     32'd0);
        check("ovf_cnt",   32'(word_cnt),       32'd128);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 32'hFFFF_FFFF;
        ld_if.ld_last  = 1'b1;
        step();
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        check("ovf_129_cnt",  32'(word_cnt),  32'd128);
        check("ovf_129_err",  32'(load_err),  32'd1);
        check("ovf_129_done", 32'(load_done), 32'd0);
        fetch("ovf_ir", 32'h0, 32'h0);
        rst_n = 1'b0;
        step();
        check("ovf_rst_err", 32'(load_err), 32'd0);
        rst_n = 1'b1;
        wait_clear(n, bad);
        check("ovf_rst_clear_len", 32'(n), 32'd128);

        // Reset mid-load after 10 words, with a word on the bus at the reset edge.
        for (int i = 0; i < 10; i++) begin
            send_word(32'hC000_0000 | 32'(i), 1'b0);
        end
        check("mid_cnt", 32'(word_cnt), 32'd10);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 32'hBAD0_BAD0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ld_if.ld_ready), 32'd0);
        check("mid_rst_crst",  32'(core_rst_n),     32'd0);
        step();
        ld_if.ld_valid = 1'b0;
        check("mid_rst_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        wait_clear(n, bad);
        check("mid_clear_len", 32'(n), 32'd128);
        send_word(32'h2222_2222, 1'b1);
        check("mid_reload_cnt", 32'(word_cnt), 32'd1);
        fetch("mid_w0",  32'h0,  32'h2222_2222);
        fetch("mid_w1",  32'h4,  32'h0);
        fetch("mid_w9",  32'h24, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
